// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add multiplier: one WIDTH-bit add per cycle, product after WIDTH+1 cycles.
// Latency: WIDTH+1 cycles from accept to out_valid; the DONE state holds the product until out_ready.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        acc_hi_d = acc_hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        addend   = lo_q[0] ? {1'b0, a_q} : '0;
        sum      = {1'b0, acc_hi_q} + addend;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    lo_d     = b;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Carry lands in the top bit; the sum LSB drops into the low half as the multiplier shifts out.
                acc_hi_d = sum[WIDTH:1];
                lo_d     = {sum[0], lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            acc_hi_q <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            acc_hi_q <= acc_hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = {acc_hi_q, lo_q};

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed and randomized checks of shift_add_mult_ctrl at WIDTH=8 against hand-computed products.
module tb_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    shift_add_mult_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Accept one pair with out_ready high, check latency, product and return to IDLE.
    task automatic mult(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] exp,
                        input string tag);
        int n;
        a         = ta;
        b         = tb_v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_product"}, product, exp);
        tick();
        chk({tag, "_in_ready_after"}, in_ready, 1);
        chk({tag, "_out_valid_after"}, out_valid, 0);
    endtask

    logic [15:0] exp_q[$];
    int          accepted;
    int          received;
    int          cyc;
    int          n;
    logic        acc_now;
    logic        emit_now;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 16'h0000);

        // First transaction with busy/in_ready observed during RUN.
        a         = 8'h0D;
        b         = 8'h0B;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 0);
        for (int i = 2; i <= 8; i++) tick();
        chk("c8_out_valid", out_valid, 0);
        tick();
        chk("c9_out_valid", out_valid, 1);
        chk("c9_product", product, 16'h008F);
        chk("c9_in_ready", in_ready, 0);
        tick();
        chk("c10_in_ready", in_ready, 1);
        chk("c10_busy", busy, 0);

        mult(8'hFF, 8'hFF, 16'hFE01, "ff_ff");
        mult(8'h00, 8'hFF, 16'h0000, "00_ff");
        mult(8'h80, 8'h02, 16'h0100, "80_02");
        mult(8'h0D, 8'h0B, 16'h008F, "0d_0b_again");

        // Backpressure with junk in_valid pulses during RUN and DONE.
        a         = 8'h12;
        b         = 8'h34;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        a        = 8'hFF;
        b        = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 3;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp_latency", n, 9);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a        = 8'(i + 1);
            b        = 8'hA5;
            chk("bp_out_valid_hold", out_valid, 1);
            chk("bp_product_hold", product, 16'h03A8);
            chk("bp_in_ready_low", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_out_valid_at_xfer", out_valid, 1);
        chk("bp_product_at_xfer", product, 16'h03A8);
        tick();
        chk("bp_out_valid_after", out_valid, 0);
        chk("bp_in_ready_after", in_ready, 1);
        tick();
        tick();
        chk("bp_no_duplicate", out_valid, 0);
        chk("bp_idle_busy", busy, 0);

        // Reset asserted during RUN cycle 4 aborts the operation.
        a         = 8'hAA;
        b         = 8'h55;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_busy_c4", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_product", product, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            if (out_valid) chk("abort_spurious_out", out_valid, 0);
            tick();
        end
        mult(8'h03, 8'h05, 16'h000F, "03_05_post_rst");

        // Randomized traffic with a scoreboard queue.
        accepted = 0;
        received = 0;
        cyc      = 0;
        while ((accepted < 1000 || exp_q.size() != 0) && cyc < 40000) begin
            a         = 8'($urandom);
            b         = 8'($urandom);
            in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            acc_now   = in_valid && in_ready;
            emit_now  = out_valid && out_ready;
            if (in_ready && out_valid) chk("rnd_exclusive", {in_ready, out_valid}, 2'b00);
            if (emit_now) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_output", 1, 0);
                end else begin
                    chk("rnd_product", product, exp_q.pop_front());
                    received++;
                end
            end
            if (acc_now) begin
                exp_q.push_back(16'(a) * 16'(b));
                accepted++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rnd_within_budget", (cyc < 40000), 1);
        chk("rnd_accepted", accepted, 1000);
        chk("rnd_received", received, 1000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
